// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RISC-V controller: state codes, opcodes,
// instruction classes and ALUOp values.
package multicycle_control_fsm_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        ClsR  = 3'd0,
        ClsI  = 3'd1,
        ClsLd = 3'd2,
        ClsSt = 3'd3,
        ClsBr = 3'd4
    } class_e;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluRType = 2'b10;
    localparam logic [1:0] AluIType = 2'b11;

    function automatic logic [1:0] alu_op_of(class_e cls);
        case (cls)
            ClsR:    return AluRType;
            ClsI:    return AluIType;
            ClsBr:   return AluSub;
            default: return AluAdd;
        endcase
    endfunction

    function automatic logic alu_src_of(class_e cls);
        return (cls == ClsI) || (cls == ClsLd) || (cls == ClsSt);
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_decoder.sv
// Combinational opcode classifier; reusable by a single-cycle controller.
module multicycle_control_fsm_decoder
    import multicycle_control_fsm_pkg::*;
(
    input  logic [6:0] opcode,
    output class_e     op_class,
    output logic       legal
);

    always_comb begin
        op_class = ClsR;
        legal    = 1'b1;
        case (opcode)
            OpR:      op_class = ClsR;
            OpI:      op_class = ClsI;
            OpLoad:   op_class = ClsLd;
            OpStore:  op_class = ClsSt;
            OpBranch: op_class = ClsBr;
            default:  legal    = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control unit: sequences fetch/decode/exec/mem/write-back and drives
// datapath selectors and strobes, with ready handshakes on both memories.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       alu_zero,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       dmem_read,
    output logic       dmem_write,
    output logic       illegal_op,
    output logic [2:0] state_o
);

    state_e state_q, state_d;
    class_e class_q, class_d;
    class_e dec_class;
    logic   dec_legal;

    multicycle_control_fsm_decoder u_decoder (
        .opcode   (opcode),
        .op_class (dec_class),
        .legal    (dec_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            class_q <= ClsR;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        class_d    = class_q;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src    = 1'b0;
        alu_op     = AluAdd;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        illegal_op = 1'b0;

        // Selectors held from the class register for the rest of the instruction
        if (state_q == StExec || state_q == StMem || state_q == StWb) begin
            alu_src = alu_src_of(class_q);
            alu_op  = alu_op_of(class_q);
        end

        case (state_q)
            StFetch: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                if (dec_legal) begin
                    class_d = dec_class;
                    state_d = StExec;
                end else begin
                    illegal_op = 1'b1;
                    state_d    = StFetch;
                end
            end
            StExec: begin
                case (class_q)
                    ClsR, ClsI:   state_d = StWb;
                    ClsLd, ClsSt: state_d = StMem;
                    ClsBr: begin
                        pc_write = alu_zero;
                        pc_src   = 1'b1;
                        state_d  = StFetch;
                    end
                    default:      state_d = StFetch;
                endcase
            end
            StMem: begin
                if (class_q == ClsSt) begin
                    dmem_write = 1'b1;
                    if (dmem_ready) state_d = StFetch;
                end else begin
                    dmem_read = 1'b1;
                    if (dmem_ready) state_d = StWb;
                end
            end
            StWb: begin
                reg_write  = 1'b1;
                mem_to_reg = (class_q == ClsLd);
                state_d    = StFetch;
            end
            default: state_d = StFetch;
        endcase

        // Reset kills every strobe immediately, independent of the clock
        if (!rst_n) begin
            imem_req   = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 1'b0;
            alu_src    = 1'b0;
            alu_op     = AluAdd;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            dmem_read  = 1'b0;
            dmem_write = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-instruction cycle sequences,
// wait states, branch outcomes, illegal opcode and asynchronous reset.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       alu_zero;
    logic       imem_ready;
    logic       dmem_ready;
    logic       imem_req, ir_write, pc_write, pc_src, alu_src;
    logic [1:0] alu_op;
    logic       mem_to_reg, reg_write, dmem_read, dmem_write, illegal_op;
    logic [2:0] state_o;

    int total = 0;
    int bad   = 0;

    multicycle_control_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .alu_zero   (alu_zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .dmem_read  (dmem_read),
        .dmem_write (dmem_write),
        .illegal_op (illegal_op),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] all_outs();
        return {imem_req, ir_write, pc_write, pc_src, alu_src, alu_op, mem_to_reg,
                reg_write, dmem_read, dmem_write, illegal_op, state_o};
    endfunction

    // Tasks below start and end one time unit after a rising edge, with state FETCH.
    task automatic test_reset();
        logic [15:0] v;
        rst_n = 1'b0; opcode = 7'b0000011; alu_zero = 1'b0;
        imem_ready = 1'b1; dmem_ready = 1'b0;
        #3;
        v = all_outs();
        total++;
        if (v !== 16'h0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=%h", v, 16'h0);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        total++;
        if (state_o !== 3'd0 || imem_req !== 1'b1) begin
            bad++; $display("FAIL reset_release got state=%0d imem_req=%b exp state=0 imem_req=1",
                            state_o, imem_req);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (state_o !== 3'd3 || dmem_read !== 1'b1) begin
            bad++; $display("FAIL reach_mem got state=%0d dmem_read=%b exp state=3 dmem_read=1",
                            state_o, dmem_read);
        end
        rst_n = 1'b0; #1;
        v = all_outs();
        total++;
        if (v !== 16'h0) begin
            bad++; $display("FAIL reset_mid_mem got=%h exp=%h", v, 16'h0);
        end
        imem_ready = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (state_o !== 3'd0 || imem_req !== 1'b1 || ir_write !== 1'b0) begin
            bad++; $display("FAIL post_reset_fetch got state=%0d req=%b irw=%b exp 0 1 0",
                            state_o, imem_req, ir_write);
        end
        imem_ready = 1'b1; dmem_ready = 1'b1;
    endtask

    task automatic test_add();
        logic [2:0] exp_st [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
        opcode = 7'b0110011;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (state_o !== exp_st[c] || reg_write !== (c == 3)) begin
                bad++; $display("FAIL add_c%0d got state=%0d rw=%b exp state=%0d rw=%b",
                                c, state_o, reg_write, exp_st[c], (c == 3));
            end
            if (c == 0) begin
                total++;
                if (ir_write !== 1'b1 || pc_write !== 1'b1 || pc_src !== 1'b0) begin
                    bad++; $display("FAIL add_fetch got irw=%b pcw=%b src=%b exp 1 1 0",
                                    ir_write, pc_write, pc_src);
                end
            end
            if (c == 3) begin
                total++;
                if (mem_to_reg !== 1'b0 || alu_src !== 1'b0 || alu_op !== 2'b10) begin
                    bad++; $display("FAIL add_wb got m2r=%b src=%b op=%b exp 0 0 10",
                                    mem_to_reg, alu_src, alu_op);
                end
            end
            @(posedge clk); #1;
        end
        total++;
        if (state_o !== 3'd0) begin
            bad++; $display("FAIL add_end got state=%0d exp 0", state_o);
        end
    endtask

    task automatic test_addi();
        logic [2:0] exp_st [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
        opcode = 7'b0010011;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (state_o !== exp_st[c]) begin
                bad++; $display("FAIL addi_c%0d got state=%0d exp %0d", c, state_o, exp_st[c]);
            end
            if (c == 2) begin
                total++;
                if (alu_src !== 1'b1 || alu_op !== 2'b11) begin
                    bad++; $display("FAIL addi_exec got src=%b op=%b exp 1 11", alu_src, alu_op);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_wait();
        logic [2:0] exp_st [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4};
        opcode = 7'b0000011;
        for (int c = 0; c < 7; c++) begin
            dmem_ready = !(c == 3 || c == 4);
            @(negedge clk);
            total++;
            if (state_o !== exp_st[c] || dmem_read !== (c >= 3 && c <= 5) || dmem_write !== 1'b0) begin
                bad++; $display("FAIL lw_c%0d got state=%0d rd=%b wr=%b exp state=%0d rd=%b wr=0",
                                c, state_o, dmem_read, dmem_write, exp_st[c], (c >= 3 && c <= 5));
            end
            if (c >= 2) begin
                total++;
                if (alu_src !== 1'b1 || alu_op !== 2'b00) begin
                    bad++; $display("FAIL lw_sel_c%0d got src=%b op=%b exp 1 00", c, alu_src, alu_op);
                end
            end
            if (c == 6) begin
                total++;
                if (mem_to_reg !== 1'b1 || reg_write !== 1'b1) begin
                    bad++; $display("FAIL lw_wb got m2r=%b rw=%b exp 1 1", mem_to_reg, reg_write);
                end
            end
            @(posedge clk); #1;
        end
        dmem_ready = 1'b1;
        total++;
        if (state_o !== 3'd0) begin
            bad++; $display("FAIL lw_end got state=%0d exp 0", state_o);
        end
    endtask

    task automatic test_store();
        logic [2:0] exp_st [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
        opcode = 7'b0100011;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (state_o !== exp_st[c] || dmem_write !== (c == 3) || dmem_read !== 1'b0
                || reg_write !== 1'b0) begin
                bad++; $display("FAIL sw_c%0d got state=%0d wr=%b rd=%b rw=%b exp state=%0d wr=%b rd=0 rw=0",
                                c, state_o, dmem_write, dmem_read, reg_write, exp_st[c], (c == 3));
            end
            @(posedge clk); #1;
        end
        total++;
        if (state_o !== 3'd0) begin
            bad++; $display("FAIL sw_end got state=%0d exp 0", state_o);
        end
    endtask

    task automatic test_beq(input logic zero);
        logic [2:0] exp_st [3] = '{3'd0, 3'd1, 3'd2};
        opcode = 7'b1100011; alu_zero = zero;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (state_o !== exp_st[c]) begin
                bad++; $display("FAIL beq%0b_c%0d got state=%0d exp %0d", zero, c, state_o, exp_st[c]);
            end
            if (c == 2) begin
                total++;
                if (pc_write !== zero || pc_src !== 1'b1 || alu_op !== 2'b01 || alu_src !== 1'b0) begin
                    bad++; $display("FAIL beq%0b_exec got pcw=%b src=%b op=%b asrc=%b exp %b 1 01 0",
                                    zero, pc_write, pc_src, alu_op, alu_src, zero);
                end
            end
            @(posedge clk); #1;
        end
        alu_zero = 1'b0;
        total++;
        if (state_o !== 3'd0) begin
            bad++; $display("FAIL beq%0b_end got state=%0d exp 0", zero, state_o);
        end
    endtask

    task automatic test_illegal();
        logic [2:0] exp_st [6] = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
        opcode = 7'b1111111;
        for (int c = 0; c < 6; c++) begin
            imem_ready = (c <= 1 || c == 5);
            @(negedge clk);
            total++;
            if (state_o !== exp_st[c] || illegal_op !== (c == 1)) begin
                bad++; $display("FAIL ill_c%0d got state=%0d ill=%b exp state=%0d ill=%b",
                                c, state_o, illegal_op, exp_st[c], (c == 1));
            end
            if (c >= 2) begin
                total++;
                if (imem_req !== 1'b1 || ir_write !== (c == 5)) begin
                    bad++; $display("FAIL ill_fetch_c%0d got req=%b irw=%b exp 1 %b",
                                    c, imem_req, ir_write, (c == 5));
                end
            end
            @(posedge clk); #1;
        end
        total++;
        if (state_o !== 3'd1) begin
            bad++; $display("FAIL ill_end got state=%0d exp 1", state_o);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_addi();
        test_load_wait();
        test_store();
        test_beq(1'b1);
        test_beq(1'b0);
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
